// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit with valid/ready
// handshake, optional accumulate mode, zero/parity flags and a counter of
// completed output transfers.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     producer handshake (in_ready is combinational)
//   a, b, op                operands and operation select
//                           (0 AND, 1 OR, 2 NOT a, 3 XOR, 4 NAND, 5 NOR,
//                            6 XNOR, 7 PASS a)
//   acc_mode                use accumulator in place of b, write result back
//   acc_clr                 synchronous accumulator clear (beats write-back)
//   out_valid / out_ready   consumer handshake
//   y, zero, parity         registered result and flags derived from it
//   acc                     accumulator value
//   done_cnt                number of accepted results, wraps
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] done_cnt
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOTA = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic             s1_acc_mode;
    logic             s2_valid;

    logic             s1_ready_c;
    logic             s2_ready_c;
    logic             in_fire_c;
    logic             s2_load_c;
    logic             out_fire_c;
    logic [WIDTH-1:0] b_eff_c;
    logic [WIDTH-1:0] result_c;

    // Ready chain depends only on stage occupancy and out_ready, never on in_valid
    assign s2_ready_c = !s2_valid || out_ready;
    assign s1_ready_c = !s1_valid || s2_ready_c;
    assign in_ready   = s1_ready_c;
    assign in_fire_c  = in_valid && s1_ready_c;
    assign s2_load_c  = s1_valid && s2_ready_c;
    assign out_fire_c = s2_valid && out_ready;
    assign out_valid  = s2_valid;

    // Result of the S1 entry; acc is read as it stands at the S2 load edge
    always_comb begin
        b_eff_c  = s1_acc_mode ? acc : s1_b;
        result_c = '0;
        case (s1_op)
            OP_AND:  result_c = s1_a & b_eff_c;
            OP_OR:   result_c = s1_a | b_eff_c;
            OP_NOTA: result_c = ~s1_a;
            OP_XOR:  result_c = s1_a ^ b_eff_c;
            OP_NAND: result_c = ~(s1_a & b_eff_c);
            OP_NOR:  result_c = ~(s1_a | b_eff_c);
            OP_XNOR: result_c = ~(s1_a ^ b_eff_c);
            OP_PASS: result_c = s1_a;
            default: result_c = '0;
        endcase
    end

    // Stage 1: operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_op       <= '0;
            s1_acc_mode <= 1'b0;
        end else begin
            if (s1_ready_c) begin
                s1_valid <= in_valid;
            end
            if (in_fire_c) begin
                s1_a        <= a;
                s1_b        <= b;
                s1_op       <= op;
                s1_acc_mode <= acc_mode;
            end
        end
    end

    // Stage 2: result and flags, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            y        <= '0;
            zero     <= 1'b1;
            parity   <= 1'b0;
        end else begin
            if (s2_ready_c) begin
                s2_valid <= s1_valid;
            end
            if (s2_load_c) begin
                y      <= result_c;
                zero   <= (result_c == '0);
                parity <= ^result_c;
            end
        end
    end

    // Accumulator: clear wins over write-back on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (s2_load_c && s1_acc_mode) begin
            acc <= result_c;
        end
    end

    // Completed output transfers, wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (out_fire_c) begin
            done_cnt <= done_cnt + CNT_W'(1);
        end
    end

endmodule
